// File: rtl/huff_hist_counter_pkg.sv
// Shared definitions for the Huffman histogram: FSM states, entry layout
// and the per-symbol initial flag pattern.
package huff_pkg;

  typedef enum logic [1:0] {IDLE, COUNT, DRAIN, DONE} state_t;

  // Entry layout: flag occupies the low FW bits, count sits directly above.
  localparam int unsigned FLAG_LSB = 0;

  function automatic int unsigned count_lsb(input int unsigned fw);
    return fw;
  endfunction

  function automatic logic [63:0] init_flag(input int unsigned i,
                                            input int unsigned nsym,
                                            input int unsigned fw);
    logic [63:0] f;
    f = '0;
    f[fw-1] = 1'b1;
    f[nsym-1-i] = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/huff_hist_counter_if.sv
// Sample handshake between the gray-data input stage and the histogram.
interface huff_hist_counter_if #(
  parameter int unsigned SYM_W = 8
);
  logic             sym_valid;
  logic [SYM_W-1:0] sym_data;
  logic             sym_ready;

  modport master (output sym_valid, output sym_data, input sym_ready);
  modport slave  (input sym_valid, input sym_data, output sym_ready);
endinterface

// File: rtl/hist_cell.sv
// One histogram entry {count, flag}: saturating count, bulk load, clear to init.
module hist_cell
  import huff_pkg::*;
#(
  parameter int unsigned   CW        = 8,
  parameter int unsigned   FW        = 7,
  parameter logic [FW-1:0] INIT_FLAG = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CW+FW-1:0] load_val,
  input  logic             inc,
  output logic [CW+FW-1:0] entry,
  output logic             sat_hit
);

  logic [CW-1:0] count;
  logic [FW-1:0] flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      flag  <= INIT_FLAG;
    end else if (clear) begin
      count <= '0;
      flag  <= INIT_FLAG;
    end else if (load) begin
      count <= load_val[count_lsb(FW) +: CW];
      flag  <= load_val[FLAG_LSB +: FW];
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // Strobe only when an increment actually reaches this cell and is blocked.
  assign sat_hit = inc && !clear && !load && (count == '1);
  assign entry   = {count, flag};

endmodule

// File: rtl/huff_hist_counter.sv
// Symbol histogram over a fixed-length burst, with PE vector load between bursts.
module huff_hist_counter
  import huff_pkg::*;
#(
  parameter int unsigned NSYM        = 6,
  parameter int unsigned CW          = 8,
  parameter int unsigned FW          = NSYM + 1,
  parameter int unsigned SYM_W       = 8,
  parameter int unsigned NUM_SAMPLES = 100
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 clear,
  input  logic                                 load_en,
  input  logic [NSYM*(CW+FW)-1:0]              load_vec,
  huff_hist_counter_if.slave                   sym_if,
  output logic [NSYM*(CW+FW)-1:0]              cnt_vec,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]     total,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 sat,
  output logic                                 bad_sym
);

  localparam int unsigned EW   = CW + FW;
  localparam int unsigned TW   = $clog2(NUM_SAMPLES + 1);
  localparam logic [TW-1:0] LAST = TW'(NUM_SAMPLES - 1);

  state_t           state;
  logic             pipe_valid;
  logic [SYM_W-1:0] pipe_sym;
  logic [NSYM-1:0]  inc;
  logic [NSYM-1:0]  sat_hit;
  logic             accept;
  logic             load;
  logic             pipe_bad;

  assign accept   = sym_if.sym_valid && sym_if.sym_ready;
  assign load     = load_en && (state == IDLE);
  assign pipe_bad = pipe_valid && ((pipe_sym == '0) || (pipe_sym > SYM_W'(NSYM)));

  always_comb begin
    inc = '0;
    for (int unsigned i = 0; i < NSYM; i++) begin
      inc[i] = pipe_valid && (pipe_sym == SYM_W'(i + 1));
    end
  end

  for (genvar g = 0; g < NSYM; g++) begin : g_cell
    localparam logic [63:0] INIT_FULL = init_flag(g, NSYM, FW);
    hist_cell #(
      .CW        (CW),
      .FW        (FW),
      .INIT_FLAG (INIT_FULL[FW-1:0])
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .load     (load),
      .load_val (load_vec[g*EW +: EW]),
      .inc      (inc[g]),
      .entry    (cnt_vec[g*EW +: EW]),
      .sat_hit  (sat_hit[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      total            <= '0;
      sym_if.sym_ready <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      sat              <= 1'b0;
      bad_sym          <= 1'b0;
      pipe_valid       <= 1'b0;
      pipe_sym         <= '0;
    end else if (clear) begin
      state            <= IDLE;
      total            <= '0;
      sym_if.sym_ready <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      sat              <= 1'b0;
      bad_sym          <= 1'b0;
      pipe_valid       <= 1'b0;
      pipe_sym         <= '0;
    end else begin
      pipe_valid <= accept;
      if (accept) pipe_sym <= sym_if.sym_data;
      if (|sat_hit) sat <= 1'b1;
      if (pipe_bad) bad_sym <= 1'b1;
      // The start branch below overrides the sticky sets above on its edge.
      case (state)
        IDLE: begin
          if (start) begin
            state            <= COUNT;
            total            <= '0;
            sat              <= 1'b0;
            bad_sym          <= 1'b0;
            sym_if.sym_ready <= 1'b1;
            busy             <= 1'b1;
          end
        end
        COUNT: begin
          if (accept) begin
            total <= total + 1'b1;
            if (total == LAST) begin
              state            <= DRAIN;
              sym_if.sym_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_huff_hist_counter.sv
// Bench for huff_hist_counter: burst-level histogram model plus literal checks.
module tb_huff_hist_counter;

  localparam int NSYM = 6;
  localparam int CW   = 8;
  localparam int FW   = 7;
  localparam int EW   = CW + FW;
  localparam int NS   = 100;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 clear = 1'b0;
  logic                 load_en = 1'b0;
  logic [NSYM*EW-1:0]   load_vec = '0;
  logic [NSYM*EW-1:0]   cnt_vec;
  logic [6:0]           total;
  logic                 busy, done, sat, bad_sym;

  huff_hist_counter_if #(.SYM_W(8)) sym_if ();

  huff_hist_counter #(
    .NSYM(6), .CW(8), .FW(7), .SYM_W(8), .NUM_SAMPLES(100)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .load_en(load_en), .load_vec(load_vec), .sym_if(sym_if),
    .cnt_vec(cnt_vec), .total(total), .busy(busy), .done(done),
    .sat(sat), .bad_sym(bad_sym)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [7:0] exp_c  [NSYM] = '{8'd17, 8'd17, 8'd17, 8'd17, 8'd16, 8'd16};
  logic [6:0] init_f [NSYM] = '{7'b1100000, 7'b1010000, 7'b1001000,
                                7'b1000100, 7'b1000010, 7'b1000001};

  task automatic entry_check(input string name, input int i, input logic [7:0] c, input logic [6:0] f);
    check(name, cnt_vec[i*EW +: EW], {c, f});
  endtask

  // Behavioural model: histogram updated at the instant a sample is accepted;
  // the drain latency is tracked only as cycles elapsed since the final accept.
  int         m_cnt [NSYM];
  logic [6:0] m_flg [NSYM];
  int         m_total;
  bit         m_sat, m_bad, m_burst;
  int         m_after;

  task automatic model_init();
    for (int i = 0; i < NSYM; i++) begin
      m_cnt[i] = 0;
      m_flg[i] = 7'b1000000 | (7'b0100000 >> i);
    end
    m_total = 0; m_sat = 0; m_bad = 0; m_burst = 0; m_after = -1;
  endtask

  function automatic logic [NSYM*EW-1:0] model_vec();
    logic [NSYM*EW-1:0] v;
    for (int i = 0; i < NSYM; i++) v[i*EW +: EW] = {8'(m_cnt[i]), m_flg[i]};
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin : model
    bit idle_pre, burst_pre;
    int s;
    if (reset || clear) begin
      model_init();
    end else begin
      idle_pre  = !m_burst && (m_after < 0);
      burst_pre = m_burst;
      if (m_after >= 0) m_after = (m_after == 1) ? -1 : m_after + 1;
      if (idle_pre && load_en) begin
        for (int i = 0; i < NSYM; i++) begin
          m_cnt[i] = int'(load_vec[i*EW+FW +: CW]);
          m_flg[i] = load_vec[i*EW +: FW];
        end
      end
      if (idle_pre && start) begin
        m_burst = 1; m_total = 0; m_sat = 0; m_bad = 0;
      end
      if (burst_pre && sym_if.sym_valid) begin
        m_total++;
        s = int'(sym_if.sym_data);
        if (s >= 1 && s <= NSYM) begin
          if (m_cnt[s-1] == 255) m_sat = 1;
          else m_cnt[s-1]++;
        end else begin
          m_bad = 1;
        end
        if (m_total == NS) begin
          m_burst = 0; m_after = 0;
        end
      end
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("sym_ready", sym_if.sym_ready, m_burst);
      check("busy", busy, m_burst || (m_after >= 0));
      check("done", done, m_after == 1);
      check("total", total, m_total);
      if ((!m_burst && m_after < 0) || m_after == 1) begin
        check("cnt_vec", cnt_vec, model_vec());
        check("sat", sat, m_sat);
        check("bad_sym", bad_sym, m_bad);
      end
    end
  end

  function automatic logic [7:0] sym_of(input int mode, input int k);
    if (mode == 0) return 8'((k % 6) + 1);
    if (mode == 1) return 8'd3;
    if (k % 10 == 3) return 8'd0;
    if (k % 10 == 7) return 8'd7;
    return 8'((k % 6) + 1);
  endfunction

  // abort_kind: 0 run to done, 1 clear after abort_at accepts, 2 async reset.
  task automatic burst(input int mode, input bit gaps, input int abort_at, input int abort_kind);
    int acc = 0;
    int budget = 0;
    int waited = 0;
    logic rdy;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    while (acc < NS && budget < 1000) begin
      if (abort_kind != 0 && acc == abort_at) break;
      sym_if.sym_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      sym_if.sym_data  = sym_of(mode, acc);
      if (budget == 5) begin
        load_en  = 1'b1;
        load_vec = '1;
      end
      rdy = sym_if.sym_ready;
      @(negedge clk);
      start   = 1'b0;
      load_en = 1'b0;
      if (sym_if.sym_valid && rdy) acc++;
      budget++;
    end
    sym_if.sym_valid = 1'b0;
    if (abort_kind == 1) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      for (int i = 0; i < NSYM; i++) entry_check("clear_entry", i, 8'd0, init_f[i]);
      check("clear_busy", busy, 1'b0);
      check("clear_done", done, 1'b0);
      check("clear_total", total, 7'd0);
    end else if (abort_kind == 2) begin
      #2 reset = 1'b1;
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_ready", sym_if.sym_ready, 1'b0);
      check("arst_total", total, 7'd0);
      check("arst_done", done, 1'b0);
      entry_check("arst_e0", 0, 8'd0, 7'b1100000);
      @(negedge clk);
      #2 reset = 1'b0;
    end else begin
      check("accept_budget", acc, NS);
      while (!done && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      check("done_latency", waited, 1);
      check("ready_after_last", sym_if.sym_ready, 1'b0);
      check("total_final", total, 7'd100);
      @(negedge clk);
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic do_load(input logic [NSYM*EW-1:0] v);
    @(negedge clk);
    load_vec = v;
    load_en  = 1'b1;
    @(negedge clk);
    load_en  = 1'b0;
    check("load_vec", cnt_vec, v);
  endtask

  initial begin
    logic [NSYM*EW-1:0] lv;
    sym_if.sym_valid = 1'b0;
    sym_if.sym_data  = '0;
    #12 reset = 1'b0;
    chk_en = 1;
    entry_check("rst_e0", 0, 8'd0, 7'b1100000);
    entry_check("rst_e5", 5, 8'd0, 7'b1000001);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", sym_if.sym_ready, 1'b0);
    check("rst_sat", sat, 1'b0);

    burst(0, 1'b0, 0, 0);
    for (int i = 0; i < NSYM; i++) entry_check("burst1_entry", i, exp_c[i], init_f[i]);
    check("burst1_sat", sat, 1'b0);
    check("burst1_bad", bad_sym, 1'b0);

    for (int i = 0; i < NSYM; i++) lv[i*EW +: EW] = {8'(10*i + 5), init_f[i]};
    lv[5*EW +: EW] = {8'd40, 7'b1000011};
    do_load(lv);
    entry_check("load_e5", 5, 8'd40, 7'b1000011);
    burst(0, 1'b0, 0, 0);
    entry_check("accum_e5", 5, 8'd56, 7'b1000011);
    entry_check("accum_e0", 0, 8'd22, 7'b1100000);

    do_clear();
    for (int i = 0; i < NSYM; i++) lv[i*EW +: EW] = {8'd0, init_f[i]};
    lv[2*EW +: EW] = {8'd250, init_f[2]};
    do_load(lv);
    burst(1, 1'b0, 0, 0);
    entry_check("sat_e2", 2, 8'd255, 7'b1001000);
    entry_check("sat_e0", 0, 8'd0, 7'b1100000);
    check("sat_flag", sat, 1'b1);

    do_clear();
    burst(2, 1'b0, 0, 0);
    check("bad_flag", bad_sym, 1'b1);
    check("bad_sat", sat, 1'b0);

    burst(0, 1'b0, 10, 1);
    repeat (4) @(negedge clk);

    burst(0, 1'b1, 37, 2);
    burst(0, 1'b1, 0, 0);
    for (int i = 0; i < NSYM; i++) entry_check("fresh_entry", i, exp_c[i], init_f[i]);
    check("fresh_bad", bad_sym, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
